ex_mem_stage: RTL and testbench

EX→MEM pipeline stage for the mySoC RV32 core. It sits directly downstream of the ALU and captures the ALU result `C` and branch flag `f`, together with the EX-stage control bits. It resolves branches and jumps into a registered one-cycle redirect and squashes the wrong-path instruction that follows. Stall and flush inputs come from the hazard/control logic; its registered outputs feed the data-memory stage and the forwarding network.

---
 rtl/ex_mem_stage.sv | 149 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register for the RV32 core: captures ALU result and control,
// resolves taken branches/jumps into a one-cycle registered redirect and squashes the wrong path.
module ex_mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_c,
  input  logic        ex_alu_f,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rf_we,
  input  logic        ex_mem_we,
  input  logic        ex_mem_re,
  input  logic [1:0]  ex_wb_sel,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [31:0] mem_rs2_data,
  output logic [4:0]  mem_rd,
  output logic        mem_rf_we,
  output logic        mem_mem_we,
  output logic        mem_mem_re,
  output logic [1:0]  mem_wb_sel,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        mem_misalign
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned WB_W  = 2;

  logic [XLEN-1:0]  link_c, target_c;
  logic             is_jump_c, take_c;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             rf_we_q, rf_we_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;
  logic [WB_W-1:0]  wb_sel_q, wb_sel_d;
  logic             redirect_q, redirect_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             misalign_q, misalign_d;
  logic             squash_q, squash_d;

  // Branch/jump resolution on the EX operands
  assign is_jump_c = ex_is_jal | ex_is_jalr;
  assign link_c    = ex_pc + XLEN'(4);
  assign target_c  = ex_is_jalr ? (ex_alu_c & ~XLEN'(1)) : (ex_pc + ex_imm);
  assign take_c    = ex_valid & ((ex_is_branch & ex_alu_f) | is_jump_c);

  // Next-state: flush > stall > squash > capture
  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    result_d      = result_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    rf_we_d       = rf_we_q;
    mem_we_d      = mem_we_q;
    mem_re_d      = mem_re_q;
    wb_sel_d      = wb_sel_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = misalign_q;
    squash_d      = squash_q;
    if (flush || (!stall && squash_q)) begin
      valid_d    = 1'b0;
      rf_we_d    = 1'b0;
      mem_we_d   = 1'b0;
      mem_re_d   = 1'b0;
      misalign_d = 1'b0;
      squash_d   = 1'b0;
    end else if (!stall) begin
      valid_d    = ex_valid;
      pc_d       = ex_pc;
      result_d   = is_jump_c ? link_c : ex_alu_c;
      rs2_d      = ex_rs2_data;
      rd_d       = ex_rd;
      rf_we_d    = ex_rf_we & ex_valid;
      mem_we_d   = ex_mem_we & ex_valid;
      mem_re_d   = ex_mem_re & ex_valid;
      wb_sel_d   = ex_wb_sel;
      redirect_d = take_c;
      misalign_d = take_c & (target_c[1:0] != 2'b00);
      squash_d   = take_c;
      if (take_c) redirect_pc_d = target_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      pc_q          <= RESET_PC;
      result_q      <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rf_we_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      wb_sel_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= RESET_PC;
      misalign_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      result_q      <= result_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      rf_we_q       <= rf_we_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      wb_sel_q      <= wb_sel_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
      squash_q      <= squash_d;
    end
  end

  assign mem_valid    = valid_q;
  assign mem_pc       = pc_q;
  assign mem_result   = result_q;
  assign mem_rs2_data = rs2_q;
  assign mem_rd       = rd_q;
  assign mem_rf_we    = rf_we_q;
  assign mem_mem_we   = mem_we_q;
  assign mem_mem_re   = mem_re_q;
  assign mem_wb_sel   = wb_sel_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign mem_misalign = misalign_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios plus random traffic
// checked against an instruction-level reference model.
module tb_ex_mem_stage;

  localparam logic [31:0] RP = 32'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rf_we;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  wb_sel;
    logic        redirect;
    logic [31:0] rpc;
    logic        misalign;
  } out_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, alu_c;
    logic        f;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rf_we, mem_we, mem_re;
    logic [1:0]  wb_sel;
    logic        br, jal, jalr;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_valid = 1'b0, ex_alu_f = 1'b0, ex_rf_we = 1'b0, ex_mem_we = 1'b0, ex_mem_re = 1'b0;
  logic [31:0] ex_pc = '0, ex_imm = '0, ex_alu_c = '0, ex_rs2_data = '0;
  logic [4:0]  ex_rd = '0;
  logic [1:0]  ex_wb_sel = '0;
  logic ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0, stall = 1'b0, flush = 1'b0;
  logic mem_valid, mem_rf_we, mem_mem_we, mem_mem_re, redirect, mem_misalign;
  logic [31:0] mem_pc, mem_result, mem_rs2_data, redirect_pc;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;

  int n_checks = 0;
  int n_fail = 0;
  out_t exp_q[$];
  out_t m;               // architectural view of what MEM should hold
  bit   wrong_path_owed; // a taken instruction still owes one killed successor

  always #5 clk = ~clk;

  ex_mem_stage #(.RESET_PC(RP)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_alu_c(ex_alu_c), .ex_alu_f(ex_alu_f), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we), .ex_mem_we(ex_mem_we), .ex_mem_re(ex_mem_re), .ex_wb_sel(ex_wb_sel),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_result(mem_result), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
    .mem_rf_we(mem_rf_we), .mem_mem_we(mem_mem_we), .mem_mem_re(mem_mem_re),
    .mem_wb_sel(mem_wb_sel), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_misalign(mem_misalign)
  );

  function automatic out_t sample();
    out_t a;
    a = '{valid: mem_valid, pc: mem_pc, result: mem_result, rs2: mem_rs2_data, rd: mem_rd,
          rf_we: mem_rf_we, mem_we: mem_mem_we, mem_re: mem_mem_re, wb_sel: mem_wb_sel,
          redirect: redirect, rpc: redirect_pc, misalign: mem_misalign};
    return a;
  endfunction

  // Reference: what the MEM slot should contain after one edge
  function automatic void model(in_t x, bit st, bit fl, bit rs);
    bit jump, taken;
    logic [31:0] dest;
    if (!rs) begin
      m = '0;
      m.pc = RP;
      m.rpc = RP;
      wrong_path_owed = 0;
    end else if (fl || (!st && wrong_path_owed)) begin
      m.valid = 0; m.rf_we = 0; m.mem_we = 0; m.mem_re = 0;
      m.redirect = 0; m.misalign = 0;
      wrong_path_owed = 0;
    end else if (st) begin
      m.redirect = 0;
    end else begin
      jump  = x.jal || x.jalr;
      taken = x.valid && ((x.br && x.f) || jump);
      m.valid  = x.valid;
      m.pc     = x.pc;
      m.result = jump ? x.pc + 32'd4 : x.alu_c;
      m.rs2    = x.rs2;
      m.rd     = x.rd;
      m.rf_we  = x.valid && x.rf_we;
      m.mem_we = x.valid && x.mem_we;
      m.mem_re = x.valid && x.mem_re;
      m.wb_sel = x.wb_sel;
      m.redirect = taken;
      m.misalign = 0;
      if (taken) begin
        dest = x.jalr ? (x.alu_c / 2) * 2 : x.pc + x.imm;
        m.rpc = dest;
        m.misalign = (dest % 4) != 0;
        wrong_path_owed = 1;
      end
    end
  endfunction

  function automatic in_t idle();
    in_t x;
    x = '{valid: 0, pc: 0, imm: 0, alu_c: 0, f: 0, rs2: 0, rd: 0, rf_we: 0, mem_we: 0,
          mem_re: 0, wb_sel: 0, br: 0, jal: 0, jalr: 0};
    return x;
  endfunction

  function automatic in_t rnd();
    in_t x;
    int cls;
    x = idle();
    cls = $urandom_range(0, 3);
    x.valid  = $urandom_range(0, 9) != 0;
    x.pc     = $urandom;
    x.imm    = ($urandom_range(0, 1) != 0) ? 32'($signed(12'($urandom))) : $urandom;
    x.alu_c  = $urandom;
    x.f      = $urandom_range(0, 1) != 0;
    x.rs2    = $urandom;
    x.rd     = 5'($urandom);
    x.rf_we  = $urandom_range(0, 1) != 0;
    x.mem_we = $urandom_range(0, 1) != 0;
    x.mem_re = $urandom_range(0, 1) != 0;
    x.wb_sel = 2'($urandom);
    x.br     = cls == 1;
    x.jal    = cls == 2;
    x.jalr   = cls == 3;
    return x;
  endfunction

  // Apply one cycle of stimulus, record the expectation, wait to the sampling edge
  task automatic cyc(input in_t x, input bit st, input bit fl, input bit rs);
    #1;
    rst_n = rs; stall = st; flush = fl;
    ex_valid = x.valid; ex_pc = x.pc; ex_imm = x.imm; ex_alu_c = x.alu_c; ex_alu_f = x.f;
    ex_rs2_data = x.rs2; ex_rd = x.rd; ex_rf_we = x.rf_we; ex_mem_we = x.mem_we;
    ex_mem_re = x.mem_re; ex_wb_sel = x.wb_sel;
    ex_is_branch = x.br; ex_is_jal = x.jal; ex_is_jalr = x.jalr;
    model(x, st, fl, rs);
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every sampled cycle with an outstanding expectation is compared
  always @(negedge clk) begin
    out_t a, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got v=%b pc=%h res=%h rs2=%h rd=%0d we=%b%b%b wb=%0d rdir=%b rpc=%h mis=%b, required v=%b pc=%h res=%h rs2=%h rd=%0d we=%b%b%b wb=%0d rdir=%b rpc=%h mis=%b",
                 $time, a.valid, a.pc, a.result, a.rs2, a.rd, a.rf_we, a.mem_we, a.mem_re,
                 a.wb_sel, a.redirect, a.rpc, a.misalign, e.valid, e.pc, e.result, e.rs2,
                 e.rd, e.rf_we, e.mem_we, e.mem_re, e.wb_sel, e.redirect, e.rpc, e.misalign);
      end
    end
  end

  initial begin
    in_t x;
    int guard;
    @(negedge clk);
    // Reset with random inputs
    cyc(rnd(), 1'b0, 1'b0, 1'b0);
    cyc(rnd(), 1'b0, 1'b0, 1'b0);
    chk("reset mem_valid", 32'(mem_valid), 0);
    chk("reset mem_pc", mem_pc, RP);
    chk("reset redirect_pc", redirect_pc, RP);
    chk("reset result", mem_result, 0);

    // Add passthrough
    x = idle(); x.valid = 1; x.pc = 32'h100; x.alu_c = 32'h1234; x.rf_we = 1; x.rd = 5;
    cyc(x, 0, 0, 1);
    chk("add mem_valid", 32'(mem_valid), 1);
    chk("add mem_result", mem_result, 32'h1234);
    chk("add mem_rd", 32'(mem_rd), 5);
    chk("add redirect", 32'(redirect), 0);

    // Taken branch then wrong-path instruction
    x = idle(); x.valid = 1; x.pc = 32'h200; x.imm = 32'hFFFF_FFF0; x.br = 1; x.f = 1;
    cyc(x, 0, 0, 1);
    chk("br redirect", 32'(redirect), 1);
    chk("br redirect_pc", redirect_pc, 32'h1F0);
    x = idle(); x.valid = 1; x.pc = 32'h204; x.rf_we = 1; x.rd = 7;
    cyc(x, 0, 0, 1);
    chk("br squash valid", 32'(mem_valid), 0);
    chk("br squash rf_we", 32'(mem_rf_we), 0);

    // JALR with a 3-cycle stall after capture
    x = idle(); x.valid = 1; x.pc = 32'h300; x.alu_c = 32'h455; x.jalr = 1; x.rf_we = 1;
    cyc(x, 0, 0, 1);
    chk("jalr redirect_pc", redirect_pc, 32'h454);
    chk("jalr link", mem_result, 32'h304);
    chk("jalr redirect", 32'(redirect), 1);
    x = idle(); x.valid = 1; x.pc = 32'h304; x.rf_we = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(x, 1, 0, 1);
      chk("jalr stall redirect", 32'(redirect), 0);
      chk("jalr stall hold", mem_pc, 32'h300);
    end
    cyc(x, 0, 0, 1);
    chk("jalr post-stall bubble", 32'(mem_valid), 0);

    // Wrap-around and misaligned target
    x = idle(); x.valid = 1; x.pc = 32'hFFFF_FFFC; x.imm = 8; x.jal = 1;
    cyc(x, 0, 0, 1);
    chk("wrap redirect_pc", redirect_pc, 32'h4);
    chk("wrap link", mem_result, 32'h0);
    chk("wrap misalign", 32'(mem_misalign), 0);
    cyc(idle(), 0, 0, 1);
    x.imm = 6;
    cyc(x, 0, 0, 1);
    chk("mis redirect_pc", redirect_pc, 32'h2);
    chk("mis misalign", 32'(mem_misalign), 1);
    cyc(idle(), 0, 0, 1);

    // Flush beats stall in the redirect cycle, then normal capture resumes
    x = idle(); x.valid = 1; x.pc = 32'h400; x.imm = 32'h40; x.br = 1; x.f = 1;
    cyc(x, 0, 0, 1);
    x = idle(); x.valid = 1; x.pc = 32'h404; x.rf_we = 1;
    cyc(x, 1, 1, 1);
    chk("flush valid", 32'(mem_valid), 0);
    chk("flush redirect", 32'(redirect), 0);
    chk("flush keeps redirect_pc", redirect_pc, 32'h440);
    x = idle(); x.valid = 1; x.pc = 32'h500; x.rf_we = 1; x.alu_c = 32'h55;
    cyc(x, 0, 0, 1);
    chk("after flush valid", 32'(mem_valid), 1);
    chk("after flush pc", mem_pc, 32'h500);

    // Random traffic, including reset asserted mid-redirect
    for (int i = 0; i < 3000; i++) begin
      cyc(rnd(), $urandom_range(0, 4) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 59) != 0);
    end
    cyc(idle(), 0, 0, 1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
